video_cmd_ctrl: RTL and testbench

- Consumes the decoded UART command nibbles (ctrl = opcode, value = argument) and updates the splicer's display configuration: layout mode, single-window channel, brightness, freeze.
- New settings go into shadow registers and become active only on a frame boundary (vsync rising edge), so no frame tears mid-scan.
- Every command gets a response byte. Responses are queued and paced into the UART transmitter's data/flag pair, one byte per byte-time.

---
 rtl/video_cmd_ctrl_pkg.sv | 34 +++
 rtl/video_cmd_ctrl_fifo.sv | 45 ++++
 rtl/video_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_video_cmd_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_cmd_ctrl_pkg.sv
// Shared opcodes, response codes, configuration layout and reset defaults
// for the splicer command controller.
package video_cmd_pkg;

  localparam logic [3:0] OP_MODE   = 4'h1;
  localparam logic [3:0] OP_CHAN   = 4'h2;
  localparam logic [3:0] OP_BRIGHT = 4'h3;
  localparam logic [3:0] OP_FREEZE = 4'h4;
  localparam logic [3:0] OP_STATUS = 4'hF;

  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_DUAL   = 2'd1,
    MODE_QUAD   = 2'd2,
    MODE_PIP    = 2'd3
  } disp_mode_e;

  localparam logic [1:0] MODE_RST   = MODE_QUAD;
  localparam logic [3:0] BRIGHT_RST = 4'd8;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] chan;
    logic [3:0] bright;
    logic       freeze;
  } cfg_t;

  localparam cfg_t CFG_RST = '{mode: MODE_RST, chan: 2'd0, bright: BRIGHT_RST, freeze: 1'b0};

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tx_state_e;

endpackage

// File: rtl/video_cmd_ctrl_fifo.sv
// Small synchronous FIFO for response bytes; pushes into a full FIFO are ignored.
module cmd_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt;
  logic                    wr, rd;

  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end

endmodule

// File: rtl/video_cmd_ctrl.sv
// Decodes UART command nibbles into shadow display settings, loads them on
// the frame boundary, and paces one response byte per UART byte-time.
module video_cmd_ctrl
  import video_cmd_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int TX_GAP    = CLK_FREQ / BAUD_RATE * 12,
  parameter int RSP_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ctrl_command_in,
  input  logic [3:0] value_command_in,
  input  logic       vsync_in,
  output logic [7:0] feedback_data,
  output logic       feedback_flag,
  output logic [1:0] disp_mode,
  output logic [1:0] chan_sel,
  output logic [3:0] bright_level,
  output logic       freeze_en,
  output logic       cfg_update
);
  localparam int GW = $clog2(TX_GAP + 1);

  cfg_t          shd, shd_nxt, act;
  logic          cmd_vld, vs_q, vs_rise, load;
  logic          ok, chg, clr_ovf, dirty, ovf_sticky;
  logic [3:0]    vm1;
  logic [7:0]    rsp, rsp_q;
  logic          push_q, pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  tx_state_e     st;
  logic [GW-1:0] gap_cnt;

  assign cmd_vld = |value_command_in;
  assign vs_rise = vsync_in & ~vs_q;
  assign load    = vs_rise & dirty;
  assign vm1     = value_command_in - 4'd1;

  always_comb begin
    shd_nxt = shd;
    rsp     = {ctrl_command_in, value_command_in};
    ok      = 1'b1;
    chg     = 1'b1;
    clr_ovf = 1'b0;
    case (ctrl_command_in)
      OP_MODE:   if (value_command_in <= 4'd4) shd_nxt.mode = vm1[1:0]; else ok = 1'b0;
      OP_CHAN:   if (value_command_in <= 4'd4) shd_nxt.chan = vm1[1:0]; else ok = 1'b0;
      OP_BRIGHT: begin
        if (value_command_in == 4'd1) begin
          if (shd.bright != 4'hF) shd_nxt.bright = shd.bright + 4'd1;
        end else if (value_command_in == 4'd2) begin
          if (shd.bright != 4'h0) shd_nxt.bright = shd.bright - 4'd1;
        end else ok = 1'b0;
      end
      OP_FREEZE: begin
        if (value_command_in == 4'd1)      shd_nxt.freeze = 1'b1;
        else if (value_command_in == 4'd2) shd_nxt.freeze = 1'b0;
        else ok = 1'b0;
      end
      OP_STATUS: begin
        chg = 1'b0;
        if (value_command_in == 4'd1) rsp = {shd.mode, shd.chan, shd.bright};
        else if (value_command_in == 4'd2) begin
          rsp     = {5'b0, ovf_sticky, dirty, shd.freeze};
          clr_ovf = 1'b1;
        end else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      shd_nxt = shd;
      rsp     = NAK_BYTE;
      chg     = 1'b0;
      clr_ovf = 1'b0;
    end
  end

  // Every acknowledged setting command marks the shadow dirty, even a saturated one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shd        <= CFG_RST;
      act        <= CFG_RST;
      dirty      <= 1'b0;
      ovf_sticky <= 1'b0;
      vs_q       <= 1'b0;
      cfg_update <= 1'b0;
      push_q     <= 1'b0;
      rsp_q      <= '0;
    end else begin
      vs_q       <= vsync_in;
      cfg_update <= load;
      if (load)    act <= shd;
      if (cmd_vld) shd <= shd_nxt;
      dirty      <= (dirty & ~load) | (cmd_vld & chg);
      push_q     <= cmd_vld;
      rsp_q      <= rsp;
      ovf_sticky <= (ovf_sticky & ~(cmd_vld & clr_ovf)) | (push_q & fifo_full);
    end
  end

  assign disp_mode    = act.mode;
  assign chan_sel     = act.chan;
  assign bright_level = act.bright;
  assign freeze_en    = act.freeze;

  cmd_rsp_fifo #(.W(8), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (rsp_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop = (st == ST_IDLE) & ~fifo_empty;

  // The strobe is registered on the pop, so it is high for the whole SEND cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st            <= ST_IDLE;
      gap_cnt       <= '0;
      feedback_flag <= 1'b0;
      feedback_data <= '0;
    end else begin
      case (st)
        ST_IDLE: if (!fifo_empty) begin
          feedback_data <= fifo_rdata;
          feedback_flag <= 1'b1;
          st            <= ST_SEND;
        end
        ST_SEND: begin
          feedback_flag <= 1'b0;
          gap_cnt       <= GW'(TX_GAP - 1);
          st            <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == '0) st <= ST_IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_cmd_ctrl.sv
// Randomised and directed bench for video_cmd_ctrl against a queue-based
// behavioural model, plus literal checks on the directed scenarios.
module tb_video_cmd_ctrl;
  localparam int CLK_FREQ  = 200;
  localparam int BAUD_RATE = 100;
  localparam int RSP_DEPTH = 4;
  localparam int TX_GAP    = CLK_FREQ / BAUD_RATE * 12;

  logic       clk = 1'b0, rst = 1'b0;
  logic [3:0] ctrl_command_in = '0, value_command_in = '0;
  logic       vsync_in = 1'b0;
  logic [7:0] feedback_data;
  logic       feedback_flag;
  logic [1:0] disp_mode, chan_sel;
  logic [3:0] bright_level;
  logic       freeze_en, cfg_update;

  video_cmd_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst), .ctrl_command_in(ctrl_command_in), .value_command_in(value_command_in),
    .vsync_in(vsync_in), .feedback_data(feedback_data), .feedback_flag(feedback_flag),
    .disp_mode(disp_mode), .chan_sel(chan_sel), .bright_level(bright_level),
    .freeze_en(freeze_en), .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, cfg_cnt = 0;
  logic [7:0] log_b[$];
  int         log_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_strobe(input string name, input int idx, input logic [7:0] b, input int at);
    checks++;
    if (idx >= log_b.size()) begin
      errors++;
      $display("FAIL %s: strobe #%0d never seen, required byte %02h", name, idx, b);
    end else if (log_b[idx] !== b || (at >= 0 && log_c[idx] != at)) begin
      errors++;
      $display("FAIL %s: got %02h at cycle %0d, required %02h at cycle %0d", name, log_b[idx], log_c[idx], b, at);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] a_mode, a_chan, s_mode, s_chan;
  logic [3:0] a_br, s_br;
  logic       a_fr, s_fr, m_dirty, m_ovf, m_vsq, m_pend, m_flag, m_cfg;
  logic [7:0] m_pend_b, m_data;
  logic [7:0] mq[$];
  int         m_edge, m_next_pop;

  task automatic m_reset();
    a_mode = 2; a_chan = 0; a_br = 8; a_fr = 0;
    s_mode = 2; s_chan = 0; s_br = 8; s_fr = 0;
    m_dirty = 0; m_ovf = 0; m_vsq = 0; m_pend = 0; m_flag = 0; m_cfg = 0;
    m_pend_b = 0; m_data = 0; mq.delete(); m_edge = 0; m_next_pop = 0;
  endtask

  task automatic m_step();
    int         pre;
    logic       o0, d0, ovf_set, ack;
    logic [3:0] op, v;
    logic [7:0] r;
    m_edge++;
    m_flag = 0; m_cfg = 0; ovf_set = 0;
    pre = mq.size();
    // a byte goes out at most once per TX_GAP+2 edges (send, gap countdown, idle)
    if (m_edge >= m_next_pop && pre > 0) begin
      m_data = mq.pop_front(); m_flag = 1; m_next_pop = m_edge + TX_GAP + 2;
    end
    o0 = m_ovf; d0 = m_dirty;
    if (vsync_in && !m_vsq && d0) begin
      a_mode = s_mode; a_chan = s_chan; a_br = s_br; a_fr = s_fr; m_cfg = 1; m_dirty = 0;
    end
    m_vsq = vsync_in;
    if (m_pend) begin
      if (pre < RSP_DEPTH) mq.push_back(m_pend_b); else ovf_set = 1;
    end
    m_pend = 0;
    if (value_command_in != 0) begin
      op = ctrl_command_in; v = value_command_in; r = {op, v}; ack = 1;
      case (op)
        4'h1: if (v <= 4) begin s_mode = 2'(v - 1); m_dirty = 1; end else ack = 0;
        4'h2: if (v <= 4) begin s_chan = 2'(v - 1); m_dirty = 1; end else ack = 0;
        4'h3: if (v == 1) begin s_br = (s_br == 15) ? 4'd15 : s_br + 1; m_dirty = 1; end
              else if (v == 2) begin s_br = (s_br == 0) ? 4'd0 : s_br - 1; m_dirty = 1; end
              else ack = 0;
        4'h4: if (v == 1 || v == 2) begin s_fr = (v == 1); m_dirty = 1; end else ack = 0;
        4'hF: if (v == 1) r = {s_mode, s_chan, s_br};
              else if (v == 2) begin r = {5'b0, o0, d0, s_fr}; m_ovf = 0; end
              else ack = 0;
        default: ack = 0;
      endcase
      m_pend = 1; m_pend_b = ack ? r : 8'hEE;
    end
    if (ovf_set) m_ovf = 1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else      m_step();
  end

  // ---------------- compare + monitor ----------------
  always @(negedge clk) begin
    chk("disp_mode", disp_mode, a_mode);
    chk("chan_sel", chan_sel, a_chan);
    chk("bright_level", bright_level, a_br);
    chk("freeze_en", freeze_en, a_fr);
    chk("cfg_update", cfg_update, m_cfg);
    chk("feedback_flag", feedback_flag, m_flag);
    chk("feedback_data", feedback_data, m_data);
    if (feedback_flag) begin log_b.push_back(feedback_data); log_c.push_back(cyc); end
    if (cfg_update) cfg_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic wait_n(input int n); repeat (n) step(); endtask

  task automatic send(input logic [3:0] op, input logic [3:0] v, output int acc);
    ctrl_command_in = op; value_command_in = v;
    step();
    acc = cyc;
    value_command_in = 0;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1; wait_n(3); vsync_in = 0; wait_n(3);
  endtask

  initial begin
    int a, base, c0;
    logic [7:0] exp5[5];
    wait_n(3);
    rst = 1;
    wait_n(2);
    chk("reset_mode", disp_mode, 2);
    chk("reset_bright", bright_level, 8);
    chk("reset_flag_data", {feedback_flag, feedback_data}, 0);

    // layout command, loads on the next frame
    base = log_b.size();
    send(4'h1, 4'h2, a);
    wait_n(5);
    chk_strobe("first_rsp", base, 8'h12, a + 2);
    chk("mode_before_vsync", disp_mode, 2);
    c0 = cfg_cnt;
    vsync_pulse();
    chk("mode_after_vsync", disp_mode, 1);
    chk("cfg_pulse_count", cfg_cnt - c0, 1);
    wait_n(TX_GAP);

    // brightness saturation
    base = log_b.size();
    for (int i = 0; i < 15; i++) begin send(4'h3, 4'h1, a); wait_n(TX_GAP + 4); end
    chk("model_bright_sat", s_br, 15);
    vsync_pulse();
    chk("bright_sat", bright_level, 15);
    chk("bright_rsp_count", log_b.size() - base, 15);
    for (int i = 0; i < 15; i++) chk_strobe("bright_rsp", base + i, 8'h31, -1);
    for (int i = 1; i < 15 && base + i < log_c.size(); i++)
      chk("strobe_spacing_ok", (log_c[base + i] - log_c[base + i - 1]) >= TX_GAP, 1);

    // NAKs change nothing
    base = log_b.size(); c0 = cfg_cnt;
    send(4'h7, 4'h3, a);
    send(4'h1, 4'h9, a);
    wait_n(2 * TX_GAP + 10);
    vsync_pulse();
    chk_strobe("nak1", base, 8'hEE, -1);
    chk_strobe("nak2", base + 1, 8'hEE, -1);
    chk("nak_no_cfg", cfg_cnt - c0, 0);

    // six back-to-back commands into a 4-deep FIFO
    base = log_b.size();
    send(4'h1, 4'h1, a); send(4'h2, 4'h2, a); send(4'h3, 4'h2, a);
    send(4'h4, 4'h1, a); send(4'h1, 4'h3, a); send(4'h2, 4'h4, a);
    wait_n(6 * (TX_GAP + 2) + 10);
    exp5 = '{8'h11, 8'h22, 8'h32, 8'h41, 8'h13};
    chk("ovf_rsp_count", log_b.size() - base, 5);
    for (int i = 0; i < 5; i++) chk_strobe("ovf_rsp", base + i, exp5[i], -1);
    chk("model_ovf", m_ovf, 1);
    send(4'hF, 4'h2, a); wait_n(TX_GAP + 8);
    chk_strobe("status_ovf_set", base + 5, 8'h07, a + 2);
    send(4'hF, 4'h2, a); wait_n(TX_GAP + 8);
    chk_strobe("status_ovf_clr", base + 6, 8'h03, a + 2);

    // command on the vsync edge loads next frame
    vsync_pulse();
    chk("flush_mode", disp_mode, 2);
    chk("flush_chan", chan_sel, 3);
    send(4'h2, 4'h1, a);
    wait_n(2);
    c0 = cfg_cnt;
    vsync_in = 1;
    send(4'h1, 4'h1, a);
    wait_n(2);
    chk("coincide_mode_old", disp_mode, 2);
    chk("coincide_chan_new", chan_sel, 0);
    vsync_in = 0; wait_n(3);
    vsync_pulse();
    chk("coincide_mode_next", disp_mode, 0);
    chk("coincide_cfg_count", cfg_cnt - c0, 2);
    wait_n(3 * TX_GAP);

    // reset during GAP with two responses queued
    send(4'h3, 4'h2, a); send(4'h3, 4'h2, a); send(4'h3, 4'h2, a);
    wait_n(6);
    rst = 0;
    #2;
    chk("rst_flag", feedback_flag, 0);
    chk("rst_data", feedback_data, 0);
    chk("rst_cfg", {disp_mode, chan_sel, bright_level, freeze_en, cfg_update}, {2'd2, 2'd0, 4'd8, 1'b0, 1'b0});
    wait_n(3);
    rst = 1;
    base = log_b.size();
    wait_n(3 * TX_GAP);
    chk("no_strobe_after_rst", log_b.size() - base, 0);
    send(4'h1, 4'h4, a);
    wait_n(5);
    chk_strobe("rsp_after_rst", base, 8'h14, a + 2);

    // randomised traffic checked cycle by cycle
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) vsync_in = ~vsync_in;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: ctrl_command_in = 4'h1;
          1: ctrl_command_in = 4'h2;
          2: ctrl_command_in = 4'h3;
          3: ctrl_command_in = 4'h4;
          4: ctrl_command_in = 4'hF;
          default: ctrl_command_in = 4'($urandom_range(0, 15));
        endcase
        value_command_in = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(1, 4));
      end else value_command_in = 0;
      step();
    end
    value_command_in = 0;
    wait_n(6 * (TX_GAP + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
